// File: rtl/signal_sequencer_pkg.sv
// Shared encodings for the traffic-signal sequencer: FSM state codes,
// lamp bit positions on the LED bus and parameter selector codes.
package signal_sequencer_pkg;

  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MG2   = 3'd1,
    S_MY    = 3'd2,
    S_WALK  = 3'd3,
    S_SG    = 3'd4,
    S_SY    = 3'd5,
    S_FLASH = 3'd6
  } state_e;

  localparam int LED_MAIN_R = 0;
  localparam int LED_MAIN_Y = 1;
  localparam int LED_MAIN_G = 2;
  localparam int LED_SIDE_R = 3;
  localparam int LED_SIDE_Y = 4;
  localparam int LED_SIDE_G = 5;
  localparam int LED_WALK   = 6;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;

endpackage

// File: rtl/signal_sequencer_tick_divider.sv
// Timing-tick generator: strobes tick once every TICK_DIV clocks and can be
// restarted so the first tick after a restart lands TICK_DIV cycles later.
module tick_divider #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic Reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (restart || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/signal_sequencer.sv
// Traffic-signal core: parameter store, interval timer, walk latch and phase
// FSM driving the 7-bit lamp bus, with a night flash mode.
module signal_sequencer
  import signal_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned TIME_W   = 4,
  parameter int unsigned DEF_BASE = 6,
  parameter int unsigned DEF_EXT  = 3,
  parameter int unsigned DEF_YEL  = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Sensor,
  input  logic              Walk_Request,
  input  logic              Reprogram,
  input  logic              Night,
  input  logic [1:0]        Time_Parameter_Selector,
  input  logic [TIME_W-1:0] Time_Value,
  output logic [6:0]        LEDs,
  output logic [2:0]        state,
  output logic [TIME_W-1:0] remaining,
  output logic              tick
);

  localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] remaining_q, remaining_d;
  logic [TIME_W-1:0] base_q, base_d;
  logic [TIME_W-1:0] ext_q, ext_d;
  logic [TIME_W-1:0] yel_q, yel_d;
  logic              walk_q, walk_d;
  logic              flash_on_q, flash_on_d;
  logic              restart;
  logic              load_en;
  logic [TIME_W-1:0] sensor_dur;

  function automatic logic [TIME_W-1:0] clamp_dur(input logic [TIME_W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk    (clk),
    .Reset  (Reset),
    .restart(restart),
    .tick   (tick)
  );

  assign load_en    = Reprogram && (Time_Parameter_Selector != 2'd3);
  assign sensor_dur = clamp_dur(Sensor ? ext_q : base_q);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    base_d      = base_q;
    ext_d       = ext_q;
    yel_d       = yel_q;
    flash_on_d  = flash_on_q;
    walk_d      = walk_q | Walk_Request;
    restart     = 1'b0;

    // A parameter load overrides any expiry happening in the same cycle.
    if (load_en) begin
      case (Time_Parameter_Selector)
        SEL_BASE: base_d = Time_Value;
        SEL_EXT:  ext_d  = Time_Value;
        SEL_YEL:  yel_d  = Time_Value;
        default:  ;
      endcase
      restart = 1'b1;
      if (state_q != S_FLASH) begin
        state_d     = S_MG;
        remaining_d = clamp_dur(base_d);
      end
    end else if (tick) begin
      if (state_q == S_FLASH) begin
        if (!Night) begin
          state_d     = S_MG;
          remaining_d = clamp_dur(base_q);
          restart     = 1'b1;
        end else begin
          flash_on_d = !flash_on_q;
        end
      end else if (remaining_q == ONE) begin
        restart = 1'b1;
        case (state_q)
          S_MG: begin
            state_d     = S_MG2;
            remaining_d = sensor_dur;
          end
          S_MG2: begin
            state_d     = S_MY;
            remaining_d = clamp_dur(yel_q);
          end
          S_MY: begin
            state_d     = walk_q ? S_WALK : S_SG;
            remaining_d = walk_q ? clamp_dur(ext_q) : sensor_dur;
          end
          S_WALK: begin
            state_d     = S_SG;
            remaining_d = sensor_dur;
          end
          S_SG: begin
            state_d     = S_SY;
            remaining_d = clamp_dur(yel_q);
          end
          S_SY: begin
            state_d     = Night ? S_FLASH : S_MG;
            remaining_d = Night ? '0 : clamp_dur(base_q);
            flash_on_d  = 1'b1;
          end
          default: ;
        endcase
      end else begin
        remaining_d = remaining_q - ONE;
      end
    end

    // Serving the walk phase consumes the request, even one arriving now.
    if (state_d == S_WALK && state_q != S_WALK) begin
      walk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_MG;
      remaining_q <= TIME_W'(DEF_BASE);
      base_q      <= TIME_W'(DEF_BASE);
      ext_q       <= TIME_W'(DEF_EXT);
      yel_q       <= TIME_W'(DEF_YEL);
      walk_q      <= 1'b0;
      flash_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      base_q      <= base_d;
      ext_q       <= ext_d;
      yel_q       <= yel_d;
      walk_q      <= walk_d;
      flash_on_q  <= flash_on_d;
    end
  end

  always_comb begin
    LEDs = '0;
    case (state_q)
      S_MG, S_MG2: begin
        LEDs[LED_MAIN_G] = 1'b1;
        LEDs[LED_SIDE_R] = 1'b1;
      end
      S_MY: begin
        LEDs[LED_MAIN_Y] = 1'b1;
        LEDs[LED_SIDE_R] = 1'b1;
      end
      S_WALK: begin
        LEDs[LED_MAIN_R] = 1'b1;
        LEDs[LED_SIDE_R] = 1'b1;
        LEDs[LED_WALK]   = 1'b1;
      end
      S_SG: begin
        LEDs[LED_MAIN_R] = 1'b1;
        LEDs[LED_SIDE_G] = 1'b1;
      end
      S_SY: begin
        LEDs[LED_MAIN_R] = 1'b1;
        LEDs[LED_SIDE_Y] = 1'b1;
      end
      S_FLASH: begin
        LEDs[LED_MAIN_Y] = flash_on_q;
        LEDs[LED_SIDE_R] = flash_on_q;
      end
      default: ;
    endcase
  end

  assign state     = state_q;
  assign remaining = remaining_q;

endmodule
